// File: rtl/inta_sequencer.sv
// 8259-style interrupt-acknowledge sequencer.
// Tracks the two CPU INTA pulses, freezes the winning request at the first
// falling edge, drives or matches the cascade bus depending on role, gates the
// vector onto the data bus during the second pulse and issues ISR strobes.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no acknowledge in progress, waiting for an armed INTA fall
// ACK1  | first INTA pulse low, request frozen
// GAP   | between pulses, gap counter running toward abort
// ACK2  | second INTA pulse low, vector driven if this device owns it
module inta_sequencer #(
  parameter int GAP_TIMEOUT = 64,
  parameter int CNT_W       = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       intaN,
  input  logic       SNGL,
  input  logic       SP,
  input  logic       AEOI,
  input  logic [7:0] slaveReg,
  input  logic       reqValid,
  input  logic [2:0] reqId,
  input  logic [2:0] cascIn,
  output logic [2:0] cascOut,
  output logic       cascOe,
  output logic       vecOe,
  output logic [2:0] vecId,
  output logic       isrSet,
  output logic       isrClr,
  output logic [2:0] isrId,
  output logic       spurious,
  output logic       busy,
  output logic       abort
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK1 = 2'd1,
    ST_GAP  = 2'd2,
    ST_ACK2 = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ROLE_SINGLE = 2'd0,
    ROLE_MASTER = 2'd1,
    ROLE_SLAVE  = 2'd2
  } role_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GAP_TIMEOUT - 1);

  state_t           state;
  role_t            role_q;
  role_t            role_now;
  logic             inta_s1;
  logic             inta_s2;
  logic             inta_d;
  logic             inta_fall;
  logic             inta_rise;
  logic             armed;
  logic             req_at_fall;
  logic             sel;
  logic             set_issued;
  logic [CNT_W-1:0] gap_cnt;
  logic [2:0]       grant;
  logic             grant_spur;
  logic             slave_match;
  logic             vec_en;

  // Two-flop synchroniser plus one delay stage for edge detection. Resetting to
  // 0 means a pin held low through reset never looks like a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inta_s1 <= 1'b0;
      inta_s2 <= 1'b0;
      inta_d  <= 1'b0;
    end else begin
      inta_s1 <= intaN;
      inta_s2 <= inta_s1;
      inta_d  <= inta_s2;
    end
  end

  assign inta_fall = inta_d & ~inta_s2;
  assign inta_rise = ~inta_d & inta_s2;

  // Acknowledges are only accepted once INTA has been observed high after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) armed <= 1'b0;
    else if (inta_s2) armed <= 1'b1;
  end

  // Role decode from the live configuration pins, used while idle.
  always_comb begin
    role_now = ROLE_SLAVE;
    if (SNGL) role_now = ROLE_SINGLE;
    else if (SP) role_now = ROLE_MASTER;
  end

  // Winning request at the first fall; no request means a spurious IR7 ack.
  always_comb begin
    grant      = reqValid ? reqId : 3'd7;
    grant_spur = !reqValid;
  end

  // Slave selection by the master's cascade code against our own ID.
  assign slave_match = (cascIn == slaveReg[2:0]) && req_at_fall;

  // Whether this device supplies the vector byte during the second pulse.
  always_comb begin
    vec_en = 1'b0;
    case (role_q)
      ROLE_SINGLE: vec_en = 1'b1;
      ROLE_MASTER: vec_en = !slaveReg[vecId];
      ROLE_SLAVE:  vec_en = sel;
      default:     vec_en = 1'b0;
    endcase
  end

  assign busy = (state != ST_IDLE);

  // Acknowledge sequencer with registered outputs and one-cycle strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      role_q      <= ROLE_SINGLE;
      req_at_fall <= 1'b0;
      sel         <= 1'b0;
      set_issued  <= 1'b0;
      gap_cnt     <= '0;
      cascOut     <= 3'd0;
      cascOe      <= 1'b0;
      vecOe       <= 1'b0;
      vecId       <= 3'd0;
      isrSet      <= 1'b0;
      isrClr      <= 1'b0;
      isrId       <= 3'd0;
      spurious    <= 1'b0;
      abort       <= 1'b0;
    end else begin
      isrSet <= 1'b0;
      isrClr <= 1'b0;
      abort  <= 1'b0;
      case (state)
        ST_IDLE: begin
          role_q <= role_now;
          if (inta_fall && armed) begin
            vecId       <= grant;
            isrId       <= grant;
            spurious    <= grant_spur;
            req_at_fall <= reqValid;
            if ((role_now != ROLE_SLAVE) && !grant_spur) begin
              isrSet     <= 1'b1;
              set_issued <= 1'b1;
            end
            if ((role_now == ROLE_MASTER) && slaveReg[grant] && !grant_spur) begin
              cascOut <= grant;
              cascOe  <= 1'b1;
            end
            state <= ST_ACK1;
          end
        end
        ST_ACK1: begin
          if (inta_rise) begin
            if ((role_q == ROLE_SLAVE) && slave_match) begin
              sel        <= 1'b1;
              isrSet     <= 1'b1;
              set_issued <= 1'b1;
            end
            gap_cnt <= '0;
            state   <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (inta_fall) begin
            vecOe <= vec_en;
            state <= ST_ACK2;
          end else if (gap_cnt == CNT_LAST) begin
            // Timeout: an ISR bit already set is left for software to clear.
            abort      <= 1'b1;
            cascOe     <= 1'b0;
            cascOut    <= 3'd0;
            spurious   <= 1'b0;
            sel        <= 1'b0;
            set_issued <= 1'b0;
            state      <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + CNT_W'(1);
          end
        end
        ST_ACK2: begin
          if (inta_rise) begin
            vecOe   <= 1'b0;
            cascOe  <= 1'b0;
            cascOut <= 3'd0;
            if (AEOI && set_issued) begin
              isrClr <= 1'b1;
              isrId  <= vecId;
            end
            sel        <= 1'b0;
            spurious   <= 1'b0;
            set_issued <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inta_sequencer.sv
// Directed bench for inta_sequencer: single, master, slave, spurious, gap
// timeout and asynchronous reset during an acknowledge.
module tb_inta_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       intaN;
  logic       SNGL;
  logic       SP;
  logic       AEOI;
  logic [7:0] slaveReg;
  logic       reqValid;
  logic [2:0] reqId;
  logic [2:0] cascIn;
  logic [2:0] cascOut;
  logic       cascOe;
  logic       vecOe;
  logic [2:0] vecId;
  logic       isrSet;
  logic       isrClr;
  logic [2:0] isrId;
  logic       spurious;
  logic       busy;
  logic       abort;

  int n_assert = 0;
  int n_fail   = 0;

  int         set_cnt   = 0;
  int         clr_cnt   = 0;
  int         abort_cnt = 0;
  int         vec_cnt   = 0;
  int         both_cnt  = 0;
  logic [2:0] set_id    = 3'd0;
  logic [2:0] clr_id    = 3'd0;

  int s_set, s_clr, s_abort, s_vec;

  inta_sequencer #(.GAP_TIMEOUT(64), .CNT_W(7)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .intaN    (intaN),
    .SNGL     (SNGL),
    .SP       (SP),
    .AEOI     (AEOI),
    .slaveReg (slaveReg),
    .reqValid (reqValid),
    .reqId    (reqId),
    .cascIn   (cascIn),
    .cascOut  (cascOut),
    .cascOe   (cascOe),
    .vecOe    (vecOe),
    .vecId    (vecId),
    .isrSet   (isrSet),
    .isrClr   (isrClr),
    .isrId    (isrId),
    .spurious (spurious),
    .busy     (busy),
    .abort    (abort)
  );

  always #5 clk = ~clk;

  // Strobe and level bookkeeping, sampled mid-cycle.
  always @(negedge clk) begin
    if (isrSet) begin
      set_cnt <= set_cnt + 1;
      set_id  <= isrId;
    end
    if (isrClr) begin
      clr_cnt <= clr_cnt + 1;
      clr_id  <= isrId;
    end
    if (isrSet && isrClr) both_cnt <= both_cnt + 1;
    if (abort) abort_cnt <= abort_cnt + 1;
    if (vecOe) vec_cnt <= vec_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_inta(input logic v);
    @(negedge clk);
    intaN = v;
  endtask

  // Pulse low for 5 cycles; returns while the DUT is inside the pulse.
  task automatic lo_start();
    drive_inta(1'b0);
    cyc(4);
  endtask

  // Release INTA and let the rise propagate.
  task automatic hi_start();
    drive_inta(1'b1);
    cyc(5);
  endtask

  task automatic snap();
    s_set   = set_cnt;
    s_clr   = clr_cnt;
    s_abort = abort_cnt;
    s_vec   = vec_cnt;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    intaN = 1'b1;
    cyc(3);
    rst_n = 1'b1;
    cyc(5);
  endtask

  initial begin
    int n;
    rst_n    = 1'b0;
    intaN    = 1'b1;
    SNGL     = 1'b1;
    SP       = 1'b0;
    AEOI     = 1'b0;
    slaveReg = 8'h00;
    reqValid = 1'b1;
    reqId    = 3'd3;
    cascIn   = 3'd0;
    cyc(3);

    // Reset state
    chk("rst_busy", busy, 1'b0);
    chk("rst_vecOe", vecOe, 1'b0);
    chk("rst_cascOe", cascOe, 1'b0);
    chk("rst_isrSet", isrSet, 1'b0);
    chk("rst_spurious", spurious, 1'b0);
    chk("rst_vecId", vecId, 3'd0);
    rst_n = 1'b1;
    cyc(5);

    // Single 8259, IR3; reqId changes in the gap must be ignored
    snap();
    lo_start();
    chk("sgl_ack1_busy", busy, 1'b1);
    chk("sgl_ack1_vecOe", vecOe, 1'b0);
    chk("sgl_ack1_vecId", vecId, 3'd3);
    chk("sgl_ack1_set", set_cnt - s_set, 1);
    hi_start();
    reqId = 3'd5;
    chk("sgl_gap_busy", busy, 1'b1);
    chk("sgl_gap_vecOe", vecOe, 1'b0);
    lo_start();
    chk("sgl_ack2_vecOe", vecOe, 1'b1);
    chk("sgl_ack2_vecId", vecId, 3'd3);
    chk("sgl_ack2_cascOe", cascOe, 1'b0);
    hi_start();
    chk("sgl_end_busy", busy, 1'b0);
    chk("sgl_end_vecOe", vecOe, 1'b0);
    chk("sgl_set_cnt", set_cnt - s_set, 1);
    chk("sgl_set_id", set_id, 3'd3);
    chk("sgl_clr_cnt", clr_cnt - s_clr, 0);
    chk("sgl_vec_cycles", vec_cnt - s_vec, 5);

    // Master, slave on IR2, AEOI
    SNGL = 1'b0; SP = 1'b1; AEOI = 1'b1; slaveReg = 8'h04; reqId = 3'd2; reqValid = 1'b1;
    cyc(2);
    snap();
    lo_start();
    chk("mst_ack1_cascOe", cascOe, 1'b1);
    chk("mst_ack1_cascOut", cascOut, 3'd2);
    hi_start();
    chk("mst_gap_cascOe", cascOe, 1'b1);
    lo_start();
    chk("mst_ack2_cascOe", cascOe, 1'b1);
    chk("mst_ack2_vecOe", vecOe, 1'b0);
    hi_start();
    chk("mst_end_cascOe", cascOe, 1'b0);
    chk("mst_set_cnt", set_cnt - s_set, 1);
    chk("mst_set_id", set_id, 3'd2);
    chk("mst_clr_cnt", clr_cnt - s_clr, 1);
    chk("mst_clr_id", clr_id, 3'd2);
    chk("mst_vec_cycles", vec_cnt - s_vec, 0);

    // Slave ID 5: selected ack then unselected ack
    SP = 1'b0; AEOI = 1'b0; slaveReg = 8'h05; reqId = 3'd1; cascIn = 3'd5;
    cyc(2);
    snap();
    lo_start();
    chk("slv_ack1_noset", set_cnt - s_set, 0);
    hi_start();
    chk("slv_gap_set", set_cnt - s_set, 1);
    chk("slv_gap_set_id", set_id, 3'd1);
    lo_start();
    chk("slv_ack2_vecOe", vecOe, 1'b1);
    hi_start();
    chk("slv_end_busy", busy, 1'b0);
    cascIn = 3'd4;
    snap();
    lo_start();
    hi_start();
    lo_start();
    chk("slv2_ack2_vecOe", vecOe, 1'b0);
    hi_start();
    chk("slv2_set_cnt", set_cnt - s_set, 0);
    chk("slv2_vec_cycles", vec_cnt - s_vec, 0);
    chk("slv2_cascOe", cascOe, 1'b0);

    // Master spurious: no request at pulse 1
    SP = 1'b1; AEOI = 1'b1; slaveReg = 8'h04; reqValid = 1'b0; reqId = 3'd2;
    cyc(2);
    snap();
    lo_start();
    reqValid = 1'b1;
    chk("spur_ack1_spurious", spurious, 1'b1);
    chk("spur_ack1_vecId", vecId, 3'd7);
    chk("spur_ack1_cascOe", cascOe, 1'b0);
    hi_start();
    lo_start();
    chk("spur_ack2_vecOe", vecOe, 1'b1);
    hi_start();
    chk("spur_set_cnt", set_cnt - s_set, 0);
    chk("spur_clr_cnt", clr_cnt - s_clr, 0);
    chk("spur_end_spurious", spurious, 1'b0);

    // Gap timeout: abort exactly 64 GAP cycles after entry (67 cycles after pin rise)
    SNGL = 1'b1; AEOI = 1'b0; reqValid = 1'b1; reqId = 3'd6;
    cyc(2);
    snap();
    lo_start();
    drive_inta(1'b1);
    n = 1;
    while (n <= 200) begin
      @(negedge clk);
      if (abort) break;
      n++;
    end
    chk("abort_latency", n, 67);
    cyc(2);
    chk("abort_busy", busy, 1'b0);
    chk("abort_vecOe", vecOe, 1'b0);
    chk("abort_cascOe", cascOe, 1'b0);
    chk("abort_spurious", spurious, 1'b0);
    chk("abort_strobes", abort_cnt - s_abort, 1);
    chk("abort_set_cnt", set_cnt - s_set, 1);
    chk("abort_clr_cnt", clr_cnt - s_clr, 0);

    // Reset during ACK2 (master, cascade active)
    SNGL = 1'b0; SP = 1'b1; slaveReg = 8'h04; reqId = 3'd2;
    cyc(2);
    lo_start();
    hi_start();
    lo_start();
    chk("rstm_pre_cascOe", cascOe, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstm_cascOe", cascOe, 1'b0);
    chk("rstm_busy", busy, 1'b0);
    do_reset();

    // Reset during ACK2 (single, vector active), INTA held low across release
    SNGL = 1'b1; reqId = 3'd3;
    cyc(2);
    lo_start();
    hi_start();
    lo_start();
    chk("rsts_pre_vecOe", vecOe, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rsts_vecOe", vecOe, 1'b0);
    cyc(3);
    snap();
    rst_n = 1'b1;
    cyc(10);
    chk("rsts_low_noset", set_cnt - s_set, 0);
    chk("rsts_low_busy", busy, 1'b0);
    hi_start();
    lo_start();
    chk("rsts_rearm_set", set_cnt - s_set, 1);
    chk("rsts_rearm_busy", busy, 1'b1);
    hi_start();
    lo_start();
    hi_start();
    chk("rsts_end_busy", busy, 1'b0);

    chk("never_set_and_clr", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
